// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode map and FSM encoding shared by seq_alu and its bench
package alu_pkg;

  localparam int OPW = 4;

  localparam logic [OPW-1:0] ADD_OP  = 4'b0000;
  localparam logic [OPW-1:0] SUB_OP  = 4'b0001;
  localparam logic [OPW-1:0] MUL_OP  = 4'b0010;
  localparam logic [OPW-1:0] DIV_OP  = 4'b0011;
  localparam logic [OPW-1:0] AND_OP  = 4'b0100;
  localparam logic [OPW-1:0] OR_OP   = 4'b0101;
  localparam logic [OPW-1:0] XOR_OP  = 4'b0110;
  localparam logic [OPW-1:0] XNOR_OP = 4'b0111;
  localparam logic [OPW-1:0] SHL_OP  = 4'b1000;
  localparam logic [OPW-1:0] SHR_OP  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_div.sv
// rtl/seq_div.sv - W-bit restoring divider, one quotient bit per clock
module seq_div #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr_common,
  input  logic         go,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         valid
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic [W:0]    sh;
  logic [W:0]    diff;

  // The dividend is shifted out of the quotient register as quotient bits shift in.
  assign sh   = {remainder, quotient[W-1]};
  assign diff = sh - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (clr_common) begin
      quotient  <= '0;
      remainder <= '0;
      dvs       <= '0;
      cnt       <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (go) begin
        quotient  <= dividend;
        remainder <= '0;
        dvs       <= divisor;
        cnt       <= CW'(W);
      end else if (cnt != '0) begin
        if (!diff[W]) begin
          remainder <= diff[W-1:0];
          quotient  <= {quotient[W-2:0], 1'b1};
        end else begin
          remainder <= sh[W-1:0];
          quotient  <= {quotient[W-2:0], 1'b0};
        end
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - strobe-loaded sequential ALU with multi-cycle divide
// Optional ALU_FLAGS_EN adds a registered {C, Z} flags output.
module seq_alu
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           clr_common,
  input  logic [W-1:0]   data,
  input  logic           ld_a,
  input  logic           ld_b,
  input  logic           ld_op,
  input  logic           start,
  output logic [2*W-1:0] O,
  output logic           busy,
  output logic           done,
`ifdef ALU_FLAGS_EN
  output logic [1:0]     flags,
`endif
  output logic           err
);

  localparam int          RW   = 2 * W;
  localparam logic [31:0] RW32 = 32'(RW);
  localparam logic [31:0] W32  = 32'(W);

  state_t         state;
  logic [W-1:0]   a, b, ea, eb;
  logic [OPW-1:0] op, eop, data_op;
  logic [RW-1:0]  res_q, alu_res, ax, bx, sum;
  logic           err_q, alu_err, alu_c;
  logic           div_go, div_valid;
  logic [W-1:0]   div_q, div_r;
`ifdef ALU_FLAGS_EN
  logic           c_q;
`endif

  generate
    if (W >= OPW) begin : g_op_slice
      assign data_op = data[OPW-1:0];
    end else begin : g_op_zext
      assign data_op = {{(OPW - W){1'b0}}, data};
    end
  endgenerate

  // Zero divisors never reach the divider; EXEC reports them as errors.
  assign div_go = (state == IDLE) && start && (op == DIV_OP) && (b != '0);

  seq_div #(.W(W)) u_div (
    .clk        (clk),
    .clr_common (clr_common),
    .go         (div_go),
    .dividend   (a),
    .divisor    (b),
    .quotient   (div_q),
    .remainder  (div_r),
    .valid      (div_valid)
  );

  always_comb begin
    ax      = {{W{1'b0}}, ea};
    bx      = {{W{1'b0}}, eb};
    sum     = ax + bx;
    alu_res = '1;
    alu_err = 1'b0;
    alu_c   = 1'b0;
    case (eop)
      ADD_OP:  begin alu_res = sum; alu_c = sum[W]; end
      SUB_OP:  begin alu_res = ax - bx; alu_c = (ea < eb); end
      MUL_OP:  alu_res = ax * bx;
      DIV_OP:  alu_err = 1'b1;
      AND_OP:  alu_res = {{W{1'b0}}, ea & eb};
      OR_OP:   alu_res = {{W{1'b0}}, ea | eb};
      XOR_OP:  alu_res = {{W{1'b0}}, ea ^ eb};
      XNOR_OP: alu_res = {{W{1'b0}}, ~(ea ^ eb)};
      SHL_OP:  alu_res = (32'(eb) >= RW32) ? '0 : (ax << eb);
      SHR_OP:  alu_res = (32'(eb) >= W32) ? '0 : {{W{1'b0}}, ea >> eb};
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr_common) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      op    <= '0;
      ea    <= '0;
      eb    <= '0;
      eop   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      O     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef ALU_FLAGS_EN
      c_q   <= 1'b0;
      flags <= 2'b00;
`endif
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (ld_a)  a  <= data;
        if (ld_b)  b  <= data;
        if (ld_op) op <= data_op;
      end
      case (state)
        IDLE: begin
          if (start) begin
            ea    <= a;
            eb    <= b;
            eop   <= op;
            busy  <= 1'b1;
            state <= ((op == DIV_OP) && (b != '0)) ? DIV : EXEC;
          end
        end
        EXEC: begin
          res_q <= alu_res;
          err_q <= alu_err;
`ifdef ALU_FLAGS_EN
          c_q   <= alu_c;
`endif
          busy  <= 1'b0;
          state <= DONE;
        end
        DIV: begin
          if (div_valid) begin
            res_q <= {div_r, div_q};
            err_q <= 1'b0;
`ifdef ALU_FLAGS_EN
            c_q   <= 1'b0;
`endif
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          O     <= res_q;
          err   <= err_q;
          done  <= 1'b1;
`ifdef ALU_FLAGS_EN
          flags <= {c_q, (res_q == '0)};
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef ALU_FLAGS_EN
  logic unused_c;
  assign unused_c = alu_c;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu at W=4
module tb_seq_alu;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           clr_common = 1'b1;
  logic [W-1:0]   data = '0;
  logic           ld_a = 1'b0, ld_b = 1'b0, ld_op = 1'b0, start = 1'b0;
  logic [2*W-1:0] O;
  logic           busy, done, err;
`ifdef ALU_FLAGS_EN
  logic [1:0]     flags;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  seq_alu #(.W(W)) dut (
    .clk        (clk),
    .clr_common (clr_common),
    .data       (data),
    .ld_a       (ld_a),
    .ld_b       (ld_b),
    .ld_op      (ld_op),
    .start      (start),
    .O          (O),
    .busy       (busy),
    .done       (done),
`ifdef ALU_FLAGS_EN
    .flags      (flags),
`endif
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [W-1:0] v);
    data = v; ld_a = 1'b1; tick(); ld_a = 1'b0;
  endtask

  task automatic load_b(input logic [W-1:0] v);
    data = v; ld_b = 1'b1; tick(); ld_b = 1'b0;
  endtask

  task automatic load_op(input logic [W-1:0] v);
    data = v; ld_op = 1'b1; tick(); ld_op = 1'b0;
  endtask

  // Pulse start, wait for done, check result/err/latency, and optionally
  // poke ld_a while busy to prove the load is ignored.
  task automatic run(input string tag, input logic [2*W-1:0] exp_o, input logic exp_err,
                     input int exp_lat, input int exp_busy, input logic [1:0] exp_flags,
                     input logic poke_a);
    int lat = 0;
    int nbusy = 0;
    start = 1'b1; tick(); start = 1'b0;
    if (busy) nbusy++;
    while (!done && lat < 40) begin
      if (poke_a && busy) begin data = 4'd2; ld_a = 1'b1; end
      tick();
      ld_a = 1'b0;
      lat++;
      if (busy) nbusy++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_o"}, 32'(O), 32'(exp_o));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_busy));
`ifdef ALU_FLAGS_EN
    check({tag, "_flags"}, 32'(flags), 32'(exp_flags));
`else
    if (exp_flags === 2'bxx) $display("flags unused");
`endif
    tick();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_o_hold"}, 32'(O), 32'(exp_o));
  endtask

  initial begin
    int spurious;
    clr_common = 1'b1;
    tick(); tick();
    check("reset_o", 32'(O), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    clr_common = 1'b0;

    load_a(4'd9);  load_b(4'd7);  load_op(4'b0000);
    run("add_9_7", 8'h10, 1'b0, 2, 1, 2'b10, 1'b0);
    load_a(4'd3);  load_b(4'd5);  load_op(4'b0001);
    run("sub_3_5", 8'hFE, 1'b0, 2, 1, 2'b10, 1'b0);
    load_a(4'd15); load_b(4'd15); load_op(4'b0010);
    run("mul_15_15", 8'hE1, 1'b0, 2, 1, 2'b00, 1'b0);
    load_a(4'd13); load_b(4'd4);  load_op(4'b0011);
    run("div_13_4", 8'h13, 1'b0, 6, 5, 2'b00, 1'b1);
    load_b(4'd0);  load_op(4'b0000);
    run("a_readback", 8'h0D, 1'b0, 2, 1, 2'b00, 1'b0);
    load_op(4'b0011);
    run("div_by_zero", 8'hFF, 1'b1, 2, 1, 2'b00, 1'b0);
    load_op(4'b1010);
    run("illegal_op", 8'hFF, 1'b1, 2, 1, 2'b00, 1'b0);
    load_a(4'd1);  load_b(4'd1);  load_op(4'b0000);
    run("add_clears_err", 8'h02, 1'b0, 2, 1, 2'b00, 1'b0);
    load_a(4'hC);  load_b(4'hA);  load_op(4'b0111);
    run("xnor_c_a", 8'h09, 1'b0, 2, 1, 2'b00, 1'b0);
    load_op(4'b0100);
    run("and_c_a", 8'h08, 1'b0, 2, 1, 2'b00, 1'b0);
    load_a(4'd3);  load_b(4'd7);  load_op(4'b1000);
    run("shl_3_7", 8'h80, 1'b0, 2, 1, 2'b00, 1'b0);
    load_b(4'd8);
    run("shl_3_8", 8'h00, 1'b0, 2, 1, 2'b01, 1'b0);
    load_a(4'd8);  load_b(4'd3);  load_op(4'b1001);
    run("shr_8_3", 8'h01, 1'b0, 2, 1, 2'b00, 1'b0);
    load_b(4'd4);
    run("shr_8_4", 8'h00, 1'b0, 2, 1, 2'b01, 1'b0);

    // Abort a division partway: O had a nonzero value beforehand.
    load_a(4'd13); load_b(4'd4); load_op(4'b0011);
    run("div_again", 8'h13, 1'b0, 6, 5, 2'b00, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("mid_div_busy", 32'(busy), 32'd1);
    clr_common = 1'b1; tick(); clr_common = 1'b0;
    check("abort_o", 32'(O), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) spurious++;
    end
    check("abort_no_done", 32'(spurious), 32'd0);
    load_a(4'd6);  load_b(4'd3);  load_op(4'b0000);
    run("add_after_abort", 8'h09, 1'b0, 2, 1, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
